// File: rtl/csync_split.sv
// csync_split -- composite-sync separator.
//
// Recovers an active-low horizontal sync and an active-high vertical sync
// from one active-low composite sync input. A flywheel dot counter
// regenerates hsync_n through the vertical interval. Once locked it
// rejects falls that land outside the expected line start.
//
// Ports:
//   clk       in   system clock (12 MHz)
//   rst_n     in   asynchronous active-low reset
//   csync     in   composite sync, active low, asynchronous to clk
//   hsync_n   out  regenerated horizontal sync, active low
//   vsync     out  vertical sync, active high
//   locked    out  flywheel locked to the input line rate
//   line_cnt  out  [8:0] line counter (only with CSYNC_SPLIT_LINE_CNT_EN)
//
// Optional feature: define CSYNC_SPLIT_LINE_CNT_EN to add line_cnt. It
// clears when vsync rises, counts dot wraps, and wraps from 312 to 0.

module csync_split #(
   parameter int LINE_TICKS = 766,
   parameter int HS_WIDTH   = 56,
   parameter int VS_MIN     = 200,
   parameter int WIN        = 16,
   parameter int LOCK_LINES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       csync,
   output logic       hsync_n,
   output logic       vsync,
   output logic       locked
`ifdef CSYNC_SPLIT_LINE_CNT_EN
   ,
   output logic [8:0] line_cnt
`endif
);

   localparam logic [9:0] DOT_LAST = 10'(LINE_TICKS - 1);
   localparam logic [9:0] WIN_LO   = 10'(LINE_TICKS - WIN);
   localparam logic [9:0] WIN_HI   = 10'(WIN);
   localparam logic [9:0] HS_W     = 10'(HS_WIDTH);
   localparam logic [9:0] VS_PRE   = 10'(VS_MIN - 1);
   localparam logic [9:0] RUN_MAX  = 10'd1023;
   localparam logic [2:0] LOCK_CNT = 3'(LOCK_LINES);

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_LOCK  = 2'd1,
      ST_VSYNC = 2'd2
   } state_t;

   logic       cs_meta_r, cs_r, cs_d_r;
   logic [9:0] run_lo_r, run_hi_r, dot_r;
   logic [2:0] match_r, match_nxt_s;
   logic [1:0] miss_r, miss_nxt_s;
   logic       seen_r, seen_nxt_s;
   logic       from_lock_r, from_lock_nxt_s;
   logic       resync_s;
   state_t     state_r, state_nxt_s;
   logic       hsync_n_r, vsync_r, locked_r;

   logic fall_s, rise_s, wrap_s, in_win_s, win_fall_s, lo_reach_s, hi_reach_s;

   assign fall_s     = cs_d_r & ~cs_r;
   assign rise_s     = ~cs_d_r & cs_r;
   assign wrap_s     = (dot_r == DOT_LAST);
   // A fall on the wrap clock is in-window by definition.
   assign in_win_s   = (dot_r >= WIN_LO) || (dot_r <= WIN_HI) || wrap_s;
   assign win_fall_s = fall_s & in_win_s;
   // Fire on the clock the run counter steps from VS_MIN-1 to VS_MIN.
   assign lo_reach_s = ~cs_r & ~fall_s & (run_lo_r == VS_PRE);
   assign hi_reach_s = cs_r & ~rise_s & (run_hi_r == VS_PRE);

   // Two-flop synchronizer plus one delay flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta_r <= 1'b1;
         cs_r      <= 1'b1;
         cs_d_r    <= 1'b1;
      end else begin
         cs_meta_r <= csync;
         cs_r      <= cs_meta_r;
         cs_d_r    <= cs_r;
      end
   end

   // Saturating low/high run-length counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_lo_r <= 10'd0;
         run_hi_r <= 10'd0;
      end else begin
         if (fall_s)
            run_lo_r <= 10'd0;
         else if (!cs_r && (run_lo_r != RUN_MAX))
            run_lo_r <= run_lo_r + 10'd1;
         if (rise_s)
            run_hi_r <= 10'd0;
         else if (cs_r && (run_hi_r != RUN_MAX))
            run_hi_r <= run_hi_r + 10'd1;
      end
   end

   // Next-state logic: hunt/lock/vsync plus match and miss accounting.
   always_comb begin
      state_nxt_s     = state_r;
      match_nxt_s     = match_r;
      miss_nxt_s      = miss_r;
      seen_nxt_s      = seen_r;
      from_lock_nxt_s = from_lock_r;
      resync_s        = 1'b0;
      case (state_r)
         ST_HUNT: begin
            miss_nxt_s = 2'd0;
            seen_nxt_s = 1'b0;
            if (lo_reach_s) begin
               state_nxt_s     = ST_VSYNC;
               from_lock_nxt_s = 1'b0;
            end else if (fall_s) begin
               resync_s = 1'b1;
               if (in_win_s)
                  match_nxt_s = match_r + 3'd1;
               else
                  match_nxt_s = 3'd1;
               if (match_nxt_s == LOCK_CNT)
                  state_nxt_s = ST_LOCK;
               else
                  state_nxt_s = ST_HUNT;
            end else begin
               state_nxt_s = ST_HUNT;
            end
         end
         ST_LOCK: begin
            // VSYNC entry wins over miss accounting on the same clock.
            if (lo_reach_s) begin
               state_nxt_s     = ST_VSYNC;
               from_lock_nxt_s = 1'b1;
            end else begin
               if (win_fall_s) begin
                  resync_s   = 1'b1;
                  miss_nxt_s = 2'd0;
               end else if (wrap_s && !seen_r) begin
                  miss_nxt_s = miss_r + 2'd1;
               end else begin
                  miss_nxt_s = miss_r;
               end
               // seen_r remembers an early in-window fall until the next wrap.
               if (wrap_s)
                  seen_nxt_s = 1'b0;
               else if (win_fall_s)
                  seen_nxt_s = 1'b1;
               else
                  seen_nxt_s = seen_r;
               if (miss_nxt_s == 2'd2) begin
                  state_nxt_s = ST_HUNT;
                  match_nxt_s = 3'd0;
                  miss_nxt_s  = 2'd0;
                  seen_nxt_s  = 1'b0;
               end else begin
                  state_nxt_s = ST_LOCK;
               end
            end
         end
         ST_VSYNC: begin
            miss_nxt_s = 2'd0;
            seen_nxt_s = 1'b0;
            if (hi_reach_s) begin
               if (from_lock_r)
                  state_nxt_s = ST_LOCK;
               else
                  state_nxt_s = ST_HUNT;
            end else begin
               state_nxt_s = ST_VSYNC;
            end
         end
         default: begin
            state_nxt_s = ST_HUNT;
            match_nxt_s = 3'd0;
            miss_nxt_s  = 2'd0;
            seen_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, flywheel bookkeeping and dot counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_HUNT;
         match_r     <= 3'd0;
         miss_r      <= 2'd0;
         seen_r      <= 1'b0;
         from_lock_r <= 1'b0;
         dot_r       <= 10'd0;
      end else begin
         state_r     <= state_nxt_s;
         match_r     <= match_nxt_s;
         miss_r      <= miss_nxt_s;
         seen_r      <= seen_nxt_s;
         from_lock_r <= from_lock_nxt_s;
         if (resync_s || wrap_s)
            dot_r <= 10'd0;
         else
            dot_r <= dot_r + 10'd1;
      end
   end

   // Registered outputs; vsync/locked follow the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_n_r <= 1'b0;
         vsync_r   <= 1'b0;
         locked_r  <= 1'b0;
      end else begin
         hsync_n_r <= (dot_r >= HS_W);
         vsync_r   <= (state_nxt_s == ST_VSYNC);
         locked_r  <= (state_nxt_s == ST_LOCK) ||
                      ((state_nxt_s == ST_VSYNC) && from_lock_nxt_s);
      end
   end

   assign hsync_n = hsync_n_r;
   assign vsync   = vsync_r;
   assign locked  = locked_r;

`ifdef CSYNC_SPLIT_LINE_CNT_EN
   logic [8:0] line_r;
   logic       vs_rise_s;

   assign vs_rise_s = (state_nxt_s == ST_VSYNC) && (state_r != ST_VSYNC);

   // Line counter: cleared as vsync rises, steps on every dot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         line_r <= 9'd0;
      else if (vs_rise_s)
         line_r <= 9'd0;
      else if (wrap_s)
         line_r <= (line_r == 9'd312) ? 9'd0 : line_r + 9'd1;
   end

   assign line_cnt = line_r;
`endif

endmodule

// File: tb/tb_csync_split.sv
// tb_csync_split -- directed self-checking bench for csync_split.
// Each line task drives one 766-clock csync line starting at a falling
// clock edge and records hsync_n/vsync/locked at every later falling edge
// (index = clocks since the line started); checks compare against
// hand-computed values.

module tb_csync_split;

   localparam int K_NORM   = 0;
   localparam int K_VERT   = 1;
   localparam int K_GLITCH = 2;
   localparam int K_DROP   = 3;

   logic clk;
   logic rst_n;
   logic csync;
   logic hsync_n;
   logic vsync;
   logic locked;
`ifdef CSYNC_SPLIT_LINE_CNT_EN
   logic [8:0] line_cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic hs_a [0:766];
   logic vs_a [0:766];
   logic lk_a [0:766];

   csync_split dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .csync   (csync),
      .hsync_n (hsync_n),
      .vsync   (vsync),
`ifdef CSYNC_SPLIT_LINE_CNT_EN
      .line_cnt(line_cnt),
`endif
      .locked  (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_line(input int kind);
      for (int j = 0; j < 766; j++) begin
         case (kind)
            K_VERT:   csync = (j >= 646 && j <= 705);
            K_GLITCH: csync = !(j < 56 || (j >= 300 && j < 305));
            K_DROP:   csync = 1'b1;
            default:  csync = (j >= 56);
         endcase
         @(negedge clk);
         hs_a[j+1] = hsync_n;
         vs_a[j+1] = vsync;
         lk_a[j+1] = locked;
      end
   endtask

   task automatic hold_high(input int n);
      csync = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_hs_aligned(input string tag);
      chk({tag, "_hs3"},  {8'd0, hs_a[3]},  9'd1);
      chk({tag, "_hs4"},  {8'd0, hs_a[4]},  9'd0);
      chk({tag, "_hs59"}, {8'd0, hs_a[59]}, 9'd0);
      chk({tag, "_hs60"}, {8'd0, hs_a[60]}, 9'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      csync = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hsync_n", {8'd0, hsync_n}, 9'd0);
      chk("rst_vsync",   {8'd0, vsync},   9'd0);
      chk("rst_locked",  {8'd0, locked},  9'd0);
`ifdef CSYNC_SPLIT_LINE_CNT_EN
      chk("rst_line_cnt", line_cnt, 9'd0);
`endif
      rst_n = 1'b1;
      hold_high(300);

      // Acquire lock: first fall is out of phase, then three aligned ones.
      run_line(K_NORM);
      run_line(K_NORM);
      run_line(K_NORM);
      chk("l3_unlocked", {8'd0, lk_a[766]}, 9'd0);
      run_line(K_NORM);
      chk("l4_lk2", {8'd0, lk_a[2]}, 9'd0);
      chk("l4_lk3", {8'd0, lk_a[3]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("l5");
      chk("l5_vs", {8'd0, vs_a[400]}, 9'd0);

      // Glitch at dot 300 must not resync.
      run_line(K_GLITCH);
      chk_hs_aligned("gl");
      chk("gl_hs320", {8'd0, hs_a[320]}, 9'd1);
      chk("gl_lk",    {8'd0, lk_a[766]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("gl_next");

      // Vertical interval.
      run_line(K_VERT);
      chk("v1_vs202", {8'd0, vs_a[202]}, 9'd0);
      chk("v1_vs203", {8'd0, vs_a[203]}, 9'd1);
      chk("v1_lk203", {8'd0, lk_a[203]}, 9'd1);
`ifdef CSYNC_SPLIT_LINE_CNT_EN
      chk("v1_line_cnt", line_cnt, 9'd0);
`endif
      run_line(K_VERT);
      chk_hs_aligned("v2");
      chk("v2_vs", {8'd0, vs_a[766]}, 9'd1);
      chk("v2_lk", {8'd0, lk_a[766]}, 9'd1);
`ifdef CSYNC_SPLIT_LINE_CNT_EN
      chk("v2_line_cnt", line_cnt, 9'd1);
`endif
      run_line(K_VERT);
      chk("v3_vs", {8'd0, vs_a[700]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("na");
      chk("na_vs258", {8'd0, vs_a[258]}, 9'd1);
      chk("na_vs259", {8'd0, vs_a[259]}, 9'd0);
      chk("na_lk259", {8'd0, lk_a[259]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("nb");
      chk("nb_lk", {8'd0, lk_a[766]}, 9'd1);
      run_line(K_NORM);

      // Dropout: three silent lines, second missed wrap drops lock.
      run_line(K_DROP);
      chk("d1_lk", {8'd0, lk_a[766]}, 9'd1);
      run_line(K_DROP);
      chk("d2_lk2", {8'd0, lk_a[2]}, 9'd1);
      chk("d2_lk3", {8'd0, lk_a[3]}, 9'd0);
      run_line(K_DROP);
      hold_high(300);
      run_line(K_NORM);
      chk("r1_hs3", {8'd0, hs_a[3]}, 9'd1);
      chk("r1_hs4", {8'd0, hs_a[4]}, 9'd0);
      chk("r1_lk",  {8'd0, lk_a[766]}, 9'd0);
      run_line(K_NORM);
      run_line(K_NORM);
      run_line(K_NORM);
      chk("r4_lk2", {8'd0, lk_a[2]}, 9'd0);
      chk("r4_lk3", {8'd0, lk_a[3]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("r5");

      // Phase step of +100 clocks.
      hold_high(100);
      run_line(K_NORM);
      chk("p1_hs4",   {8'd0, hs_a[4]},   9'd1);
      chk("p1_lk668", {8'd0, lk_a[668]}, 9'd1);
      chk("p1_lk669", {8'd0, lk_a[669]}, 9'd0);
      run_line(K_NORM);
      chk("p2_hs3", {8'd0, hs_a[3]}, 9'd1);
      chk("p2_hs4", {8'd0, hs_a[4]}, 9'd0);
      chk("p2_lk",  {8'd0, lk_a[766]}, 9'd0);
      run_line(K_NORM);
      run_line(K_NORM);
      run_line(K_NORM);
      chk("p5_lk2", {8'd0, lk_a[2]}, 9'd0);
      chk("p5_lk3", {8'd0, lk_a[3]}, 9'd1);
      run_line(K_NORM);
      chk_hs_aligned("p6");
      chk("p6_lk", {8'd0, lk_a[766]}, 9'd1);

      // Asynchronous reset in the middle of vsync.
      run_line(K_VERT);
      chk("vr_vs203", {8'd0, vs_a[203]}, 9'd1);
      chk("vr_pre_vs", {8'd0, vsync},   9'd1);
      chk("vr_pre_hs", {8'd0, hsync_n}, 9'd1);
      chk("vr_pre_lk", {8'd0, locked},  9'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_vsync",   {8'd0, vsync},   9'd0);
      chk("ar_locked",  {8'd0, locked},  9'd0);
      chk("ar_hsync_n", {8'd0, hsync_n}, 9'd0);
`ifdef CSYNC_SPLIT_LINE_CNT_EN
      chk("ar_line_cnt", line_cnt, 9'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
